// File: rtl/dec_pkg.sv
// Shared decode definitions: opcode constants, op classes and immediate formats
// for the registered RV32I/RV32E decode stage.
package dec_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      CLS_LUI      = 4'd0,
      CLS_AUIPC    = 4'd1,
      CLS_JAL      = 4'd2,
      CLS_JALR     = 4'd3,
      CLS_BRANCH   = 4'd4,
      CLS_LOAD     = 4'd5,
      CLS_STORE    = 4'd6,
      CLS_OP_IMM   = 4'd7,
      CLS_OP       = 4'd8,
      CLS_MISC_MEM = 4'd9,
      CLS_SYSTEM   = 4'd10,
      CLS_ILLEGAL  = 4'd15
   } op_class_e;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   function automatic op_class_e classify(input logic [6:0] opcode);
      case (opcode)
         OPC_LUI:      return CLS_LUI;
         OPC_AUIPC:    return CLS_AUIPC;
         OPC_JAL:      return CLS_JAL;
         OPC_JALR:     return CLS_JALR;
         OPC_BRANCH:   return CLS_BRANCH;
         OPC_LOAD:     return CLS_LOAD;
         OPC_STORE:    return CLS_STORE;
         OPC_OP_IMM:   return CLS_OP_IMM;
         OPC_OP:       return CLS_OP;
         OPC_MISC_MEM: return CLS_MISC_MEM;
         OPC_SYSTEM:   return CLS_SYSTEM;
         default:      return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/dec_comb.sv
// Purely combinational instruction decode: class, immediate, write enable,
// source-usage flags and illegal detection (including RV32E register range).
module dec_comb
   import dec_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic [31:0]     instr,
   output op_class_e       op_class,
   output logic [XLEN-1:0] imm,
   output logic            rd_we,
   output logic            rs1_used,
   output logic            rs2_used,
   output logic            illegal
);

   imm_fmt_e    fmt;
   logic        writes;
   logic [31:0] imm32;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;

   assign rd  = instr[11:7];
   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];

   function automatic logic reg_ok(input logic [4:0] f);
      return int'(f) < NREGS;
   endfunction

   always_comb begin
      op_class = classify(instr[6:0]);
      fmt      = IMM_NONE;
      writes   = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (op_class)
         CLS_LUI, CLS_AUIPC: begin fmt = IMM_U; writes = 1'b1; end
         CLS_JAL:            begin fmt = IMM_J; writes = 1'b1; end
         CLS_JALR, CLS_LOAD, CLS_OP_IMM: begin
            fmt = IMM_I; writes = 1'b1; rs1_used = 1'b1;
         end
         CLS_BRANCH: begin fmt = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1; end
         CLS_STORE:  begin fmt = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1; end
         CLS_OP:     begin writes = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
         CLS_SYSTEM: fmt = IMM_I;
         default: ;
      endcase
   end

   always_comb begin
      case (fmt)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm = XLEN'(signed'(imm32));
   end

   // rd counts as a used field whenever the class writes, even for rd == x0
   assign illegal = (op_class == CLS_ILLEGAL)
                  || (writes   && !reg_ok(rd))
                  || (rs1_used && !reg_ok(rs1))
                  || (rs2_used && !reg_ok(rs2));

   assign rd_we = writes && (rd != 5'd0) && !illegal;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshakes on both sides and a
// register scoreboard that stalls fetch on RAW/WAW hazards until writeback.
module decode_stage
   import dec_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   localparam int RA_W  = $clog2(NREGS)
) (
   input  logic            clk_i,
   input  logic            rsn_i,
   input  logic            instr_valid_i,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            instr_ready_o,
   input  logic            flush_i,
   input  logic            wb_valid_i,
   input  logic [RA_W-1:0] wb_addr_i,
   output logic            dec_valid_o,
   input  logic            dec_ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic [RA_W-1:0] read_addr_a_o,
   output logic [RA_W-1:0] read_addr_b_o,
   output logic [RA_W-1:0] write_addr_o,
   output logic            int_write_enable_o,
   output logic [XLEN-1:0] imm_o,
   output logic [3:0]      op_class_o,
   output logic [2:0]      funct3_o,
   output logic [6:0]      funct7_o,
   output logic            illegal_o
);

   op_class_e        cls_d;
   logic [XLEN-1:0]  imm_d;
   logic             we_d;
   logic             rs1_used;
   logic             rs2_used;
   logic             ill_d;
   logic [RA_W-1:0]  rs1_a;
   logic [RA_W-1:0]  rs2_a;
   logic [RA_W-1:0]  rd_a;
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_eff;
   logic [NREGS-1:0] pending_d;
   logic [NREGS-1:0] wb_mask;
   logic             hazard;
   logic             capture;

   dec_comb #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_dec (
      .instr    (instr_i),
      .op_class (cls_d),
      .imm      (imm_d),
      .rd_we    (we_d),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .illegal  (ill_d)
   );

   assign rs1_a = RA_W'(instr_i[19:15]);
   assign rs2_a = RA_W'(instr_i[24:20]);
   assign rd_a  = RA_W'(instr_i[11:7]);

   // Writeback bypass: a register retiring this cycle no longer blocks issue
   always_comb begin
      wb_mask = '0;
      if (wb_valid_i) wb_mask[wb_addr_i] = 1'b1;
      pending_eff = pending & ~wb_mask;
      hazard = (rs1_used && pending_eff[rs1_a])
            || (rs2_used && pending_eff[rs2_a])
            || (we_d     && pending_eff[rd_a]);
   end

   assign instr_ready_o = (!dec_valid_o || dec_ready_i) && !hazard && !flush_i;
   assign capture       = instr_valid_i && instr_ready_o;

   // Set is applied last so a same-cycle writeback of rd cannot cancel it
   always_comb begin
      pending_d = pending_eff;
      if (flush_i && dec_valid_o && int_write_enable_o) pending_d[write_addr_o] = 1'b0;
      if (capture && we_d) pending_d[rd_a] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         pending            <= '0;
         dec_valid_o        <= 1'b0;
         pc_o               <= '0;
         read_addr_a_o      <= '0;
         read_addr_b_o      <= '0;
         write_addr_o       <= '0;
         int_write_enable_o <= 1'b0;
         imm_o              <= '0;
         op_class_o         <= '0;
         funct3_o           <= '0;
         funct7_o           <= '0;
         illegal_o          <= 1'b0;
      end else begin
         pending <= pending_d;
         if (flush_i) begin
            dec_valid_o <= 1'b0;
         end else if (capture) begin
            dec_valid_o        <= 1'b1;
            pc_o               <= pc_i;
            read_addr_a_o      <= rs1_a;
            read_addr_b_o      <= rs2_a;
            write_addr_o       <= rd_a;
            int_write_enable_o <= we_d;
            imm_o              <= imm_d;
            op_class_o         <= cls_d;
            funct3_o           <= instr_i[14:12];
            funct7_o           <= instr_i[31:25];
            illegal_o          <= ill_d;
         end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: RV32I instance for decode, hazard,
// backpressure, flush and reset; RV32E instance for register-range legality.
module tb_decode_stage;
   import dec_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] imm;
      logic [3:0]  cls;
      logic        ill;
   } exp_t;

   int checks   = 0;
   int failures = 0;
   exp_t exp_q[$];

   logic        clk = 1'b0;
   logic        rsn;
   logic        instr_valid, flush, wb_valid, dec_ready;
   logic [31:0] instr, pc;
   logic [4:0]  wb_addr;
   logic        instr_ready, dec_valid, we, ill;
   logic [31:0] pc_o, imm;
   logic [4:0]  ra, rb, wa;
   logic [3:0]  cls;
   logic [2:0]  f3;
   logic [6:0]  f7;

   logic        instr_valid_e, instr_ready_e, dec_valid_e, we_e, ill_e;
   logic [31:0] instr_e, pc_e, pc_o_e, imm_e;
   logic [3:0]  ra_e, rb_e, wa_e, cls_e;
   logic [2:0]  f3_e;
   logic [6:0]  f7_e;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk_i(clk), .rsn_i(rsn), .instr_valid_i(instr_valid), .instr_i(instr), .pc_i(pc),
      .instr_ready_o(instr_ready), .flush_i(flush), .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
      .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .pc_o(pc_o), .read_addr_a_o(ra),
      .read_addr_b_o(rb), .write_addr_o(wa), .int_write_enable_o(we), .imm_o(imm),
      .op_class_o(cls), .funct3_o(f3), .funct7_o(f7), .illegal_o(ill)
   );

   decode_stage #(.XLEN(32), .NREGS(16)) dut_e (
      .clk_i(clk), .rsn_i(rsn), .instr_valid_i(instr_valid_e), .instr_i(instr_e), .pc_i(pc_e),
      .instr_ready_o(instr_ready_e), .flush_i(1'b0), .wb_valid_i(1'b0), .wb_addr_i(4'd0),
      .dec_valid_o(dec_valid_e), .dec_ready_i(1'b1), .pc_o(pc_o_e), .read_addr_a_o(ra_e),
      .read_addr_b_o(rb_e), .write_addr_o(wa_e), .int_write_enable_o(we_e), .imm_o(imm_e),
      .op_class_o(cls_e), .funct3_o(f3_e), .funct7_o(f7_e), .illegal_o(ill_e)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] p, input logic [4:0] r, input logic w,
                               input logic [31:0] i, input op_class_e c, input logic il);
      mk = '{pc: p, rd: r, we: w, imm: i, cls: c, ill: il};
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rsn && dec_valid && dec_ready && !flush) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("out_pc", pc_o, e.pc);
            check_eq("out_rd", wa, e.rd);
            check_eq("out_we", we, e.we);
            check_eq("out_imm", imm, e.imm);
            check_eq("out_cls", cls, e.cls);
            check_eq("out_ill", ill, e.ill);
         end
      end
   end

   // Presents one instruction; returns how many extra cycles it waited
   task automatic send(input logic [31:0] ins, input logic [31:0] p, input exp_t e, output int waited);
      instr = ins; pc = p; instr_valid = 1'b1; waited = 0;
      @(negedge clk);
      while (!instr_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!instr_ready) check_eq("accept_timeout", 64'd0, 64'd1);
      else exp_q.push_back(e);
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] a);
      wb_valid = 1'b1; wb_addr = a;
      @(posedge clk); #1;
      wb_valid = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int w;
      exp_t dropped;
      rsn = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0;
      wb_valid = 1'b0; wb_addr = '0; dec_ready = 1'b1;
      instr_valid_e = 1'b0; instr_e = '0; pc_e = '0;
      repeat (3) @(posedge clk);
      #1 rsn = 1'b1;

      @(negedge clk);
      check_eq("rst_dec_valid", dec_valid, 0);
      check_eq("rst_we", we, 0);
      check_eq("rst_imm", imm, 0);
      check_eq("rst_pc", pc_o, 0);
      check_eq("rst_fields", {ra, rb, f3, f7}, 0);
      check_eq("rst_ready", instr_ready, 1);
      check_eq("rst_pending", dut.pending, 0);
      @(posedge clk); #1;

      // ADDI x5,x1,-1
      send(32'hFFF08293, 32'h100, mk(32'h100, 5'd5, 1'b1, 32'hFFFF_FFFF, CLS_OP_IMM, 1'b0), w);
      check_eq("addi_wait", w, 0);

      // ADD x6,x5,x5 must stall until x5 writes back, then issue that same cycle
      instr = 32'h0052_8333; pc = 32'h104; instr_valid = 1'b1;
      @(negedge clk); check_eq("raw_stall0", instr_ready, 0);
      @(negedge clk); check_eq("raw_stall1", instr_ready, 0);
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_addr = 5'd5;
      @(negedge clk); check_eq("raw_bypass_ready", instr_ready, 1);
      exp_q.push_back(mk(32'h104, 5'd6, 1'b1, 32'h0, CLS_OP, 1'b0));
      @(posedge clk); #1;
      wb_valid = 1'b0; instr_valid = 1'b0;
      @(negedge clk); check_eq("raw_pending", dut.pending, 32'h0000_0040);
      @(posedge clk); #1;
      wb(5'd6);

      // Independent back-to-back instructions at full rate
      send(32'h0020_A423, 32'h108, mk(32'h108, 5'd8, 1'b0, 32'h8, CLS_STORE, 1'b0), w);
      check_eq("sw_wait", w, 0);
      send(32'h0010_00EF, 32'h10C, mk(32'h10C, 5'd1, 1'b1, 32'h800, CLS_JAL, 1'b0), w);
      check_eq("jal_wait", w, 0);
      send(32'h1234_51B7, 32'h110, mk(32'h110, 5'd3, 1'b1, 32'h1234_5000, CLS_LUI, 1'b0), w);
      check_eq("lui_wait", w, 0);
      wb(5'd1);
      wb(5'd3);
      send(32'hFE20_8EE3, 32'h114, mk(32'h114, 5'd29, 1'b0, 32'hFFFF_FFFC, CLS_BRANCH, 1'b0), w);
      send(32'h0000_0013, 32'h118, mk(32'h118, 5'd0, 1'b0, 32'h0, CLS_OP_IMM, 1'b0), w);
      send(32'h0000_007F, 32'h11C, mk(32'h11C, 5'd0, 1'b0, 32'h0, CLS_ILLEGAL, 1'b1), w);
      @(posedge clk); #1;

      // Backpressure: held ADDI x9 stays stable, ADDI x10 waits
      dec_ready = 1'b0;
      send(32'h0050_0493, 32'h120, mk(32'h120, 5'd9, 1'b1, 32'h5, CLS_OP_IMM, 1'b0), w);
      instr = 32'h0060_0513; pc = 32'h124; instr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("bp_ready", instr_ready, 0);
         check_eq("bp_valid", dec_valid, 1);
         check_eq("bp_pc", pc_o, 32'h120);
         check_eq("bp_imm", imm, 32'h5);
      end
      @(posedge clk); #1;
      dec_ready = 1'b1;
      @(negedge clk); check_eq("bp_release_ready", instr_ready, 1);
      exp_q.push_back(mk(32'h124, 5'd10, 1'b1, 32'h6, CLS_OP_IMM, 1'b0));
      @(posedge clk); #1;
      instr_valid = 1'b0;
      wb(5'd9);
      wb(5'd10);
      @(posedge clk); #1;

      // Flush the held ADDI x7; a reader of x7 must then issue without stall
      dec_ready = 1'b0;
      send(32'h0010_0393, 32'h130, mk(32'h130, 5'd7, 1'b1, 32'h1, CLS_OP_IMM, 1'b0), w);
      flush = 1'b1;
      dropped = exp_q.pop_back();
      @(negedge clk); check_eq("flush_ready", instr_ready, 0);
      @(posedge clk); #1;
      flush = 1'b0; dec_ready = 1'b1;
      @(negedge clk);
      check_eq("flush_valid", dec_valid, 0);
      check_eq("flush_pend7", dut.pending[7], 0);
      @(posedge clk); #1;
      send(32'h0033_8413, 32'h134, mk(32'h134, 5'd8, 1'b1, 32'h3, CLS_OP_IMM, 1'b0), w);
      check_eq("after_flush_wait", w, 0);
      wb(5'd8);
      repeat (2) @(posedge clk);
      #1 check_eq("sb_empty", exp_q.size(), 0);

      // RV32E: x17 out of range, 0x7F illegal, x15 legal
      instr_e = 32'h0020_88B3; pc_e = 32'h200; instr_valid_e = 1'b1;
      @(negedge clk); check_eq("e_ready", instr_ready_e, 1);
      @(posedge clk); #1; instr_valid_e = 1'b0;
      @(negedge clk);
      check_eq("e_add17_valid", dec_valid_e, 1);
      check_eq("e_add17_ill", ill_e, 1);
      check_eq("e_add17_we", we_e, 0);
      check_eq("e_add17_pend", dut_e.pending, 0);
      check_eq("e_add17_fields", {wa_e, ra_e, rb_e, cls_e}, {4'd1, 4'd1, 4'd2, 4'd8});
      check_eq("e_add17_misc", {pc_o_e, imm_e, f3_e, f7_e}, {32'h200, 32'h0, 3'd0, 7'd0});
      @(posedge clk); #1;
      instr_e = 32'h0000_007F; pc_e = 32'h204; instr_valid_e = 1'b1;
      @(posedge clk); #1; instr_valid_e = 1'b0;
      @(negedge clk);
      check_eq("e_opc7f_ill", ill_e, 1);
      check_eq("e_opc7f_cls", cls_e, 4'd15);
      @(posedge clk); #1;
      instr_e = 32'h0010_0793; pc_e = 32'h208; instr_valid_e = 1'b1;
      @(posedge clk); #1; instr_valid_e = 1'b0;
      @(negedge clk);
      check_eq("e_x15_ill", ill_e, 0);
      check_eq("e_x15_we", we_e, 1);
      check_eq("e_x15_pend", dut_e.pending, 16'h8000);

      // Reset mid-operation drops the held instruction and pending bits
      @(posedge clk); #1;
      dec_ready = 1'b0;
      send(32'h1234_51B7, 32'h140, mk(32'h140, 5'd3, 1'b1, 32'h1234_5000, CLS_LUI, 1'b0), w);
      dropped = exp_q.pop_back();
      #2 rsn = 1'b0;
      #1;
      check_eq("midrst_valid", dec_valid, 0);
      check_eq("midrst_pending", dut.pending, 0);
      check_eq("midrst_pc", pc_o, 0);
      @(posedge clk); #1 rsn = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered RV32I/RV32E decode stage that replaces the purely combinational decoder. It sits between fetch and the register file/execute stage, with a valid/ready handshake on both sides. It adds immediate generation, opcode classification and illegal-instruction detection. A register scoreboard stalls fetch on RAW/WAW hazards until writeback clears them.

## Interface
Parameters:
- XLEN, 32, datapath width for pc and immediate (32 or 64)
- NREGS, 32, architectural integer registers (32 = RV32I, 16 = RV32E)
- RA_W, $clog2(NREGS), register address width (derived, not overridable)

Ports (one clock; reset asynchronous, active-low):
- clk_i  in  1  clock
- rsn_i  in  1  asynchronous active-low reset
- instr_valid_i  in  1  fetch presents an instruction
- instr_i  in  32  instruction word
- pc_i  in  XLEN  pc of instr_i
- instr_ready_o  out  1  stage accepts instr_i this cycle
- flush_i  in  1  kill instruction held in stage, block capture this cycle
- wb_valid_i  in  1  writeback retires a register write
- wb_addr_i  in  RA_W  register being written back
- dec_valid_o  out  1  decoded instruction valid
- dec_ready_i  in  1  execute accepts decoded instruction
- pc_o  out  XLEN  registered pc
- read_addr_a_o  out  RA_W  rs1 (instr[19:15])
- read_addr_b_o  out  RA_W  rs2 (instr[24:20])
- write_addr_o  out  RA_W  rd (instr[11:7])
- int_write_enable_o  out  1  instruction writes rd
- imm_o  out  XLEN  sign-extended immediate
- op_class_o  out  4  op class (dec_pkg::op_class_e)
- funct3_o  out  3  instr[14:12]
- funct7_o  out  7  instr[31:25]
- illegal_o  out  1  illegal instruction flag

## Operation
- Classification by opcode:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, MISC_MEM 0001111, SYSTEM 1110011.
  - Anything else is ILLEGAL.
- int_write_enable:
  - 1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and only when rd != 0.
  - 0 for BRANCH, STORE, MISC_MEM, SYSTEM, ILLEGAL.
- Source usage:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - Only used sources are hazard-checked.
- Immediate formats (sign bit is instr[31], extended to XLEN):
  - I: LOAD, OP_IMM, JALR, SYSTEM
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - 0 for OP and ILLEGAL.
- illegal_o = 1 when:
  - the class is ILLEGAL, or
  - any used register field (rd, rs1, rs2) is >= NREGS; for NREGS=16, instr bit 4 of a used field is set.
- An illegal instruction has write enable 0 and sets no pending bit.
- Scoreboard: pending[NREGS-1:0], bit 0 permanently 0.
  - hazard = (rs1 used and pending_eff[rs1]) or (rs2 used and pending_eff[rs2]) or (we and pending_eff[rd]).
  - pending_eff = pending with the bit for wb_addr_i cleared when wb_valid_i (writeback bypass).
  - Capture with we=1 sets pending[rd].
  - wb_valid_i clears pending[wb_addr_i].
  - Set and clear of the same register in the same cycle: set wins.
  - wb_valid_i for a non-pending register is ignored.
- Handshake:
  - instr_ready_o = (!dec_valid_o or dec_ready_i) and !hazard and !flush_i.
  - Capture when instr_valid_i and instr_ready_o.
  - dec_valid_o holds and all outputs stay stable while dec_ready_i=0.
- flush_i:
  - Clears dec_valid_o next cycle.
  - If the held instruction has we=1, clears its pending[rd]; flush has priority over a same-cycle wb to any register.
  - Instructions already issued downstream are not affected.

## Timing
- Reset (rsn_i low, asynchronous):
  - dec_valid_o=0 and pending=0.
  - All registered outputs are 0.
  - instr_ready_o=1 once reset is released.
- Latency: one cycle from capture to dec_valid_o.
- Throughput: one instruction per cycle with dec_ready_i=1 and no hazards.
- instr_ready_o is combinational from dec_valid_o, dec_ready_i, pending, wb_valid_i/wb_addr_i, instr_i and flush_i.
- A dependent back-to-back instruction stalls until the cycle its producer's wb_valid_i is asserted. With bypass it is accepted in that cycle.
- Reset asserted mid-operation drops the held instruction and all pending bits immediately.

## Structure
- dec_pkg holds:
  - op_class_e (4-bit enum above)
  - opcode localparams
  - imm_fmt_e (I, S, B, U, J, NONE)
- Sub-module dec_comb: pure combinational decode of instr_i giving class, imm, we, rs-used flags and illegal.
- decode_stage instantiates dec_comb and adds the output register, scoreboard and handshake.

## Test plan
- Reset: after rsn_i low then high → dec_valid_o=0, int_write_enable_o=0, instr_ready_o=1, pending=0.
- Classes: ADDI x5,x1,-1 (0xFFF08293) → imm_o=0xFFFFFFFF, we=1, write_addr_o=5. SW x2,8(x1) (0x0020A423) → we=0, imm_o=8. JAL x1,+2048 → we=1, imm_o=0x800.
- RAW: ADDI x5 then ADD x6,x5,x5 → second stalled (instr_ready_o=0) until wb_valid_i with wb_addr_i=5, accepted in that cycle.
- Backpressure: dec_ready_i=0 for 3 cycles → outputs stable, instr_ready_o=0, nothing lost or duplicated.
- Flush: held ADDI x7 with flush_i=1 → next cycle dec_valid_o=0 and pending[7]=0; a following instr reading x7 is accepted with no stall.
- RV32E (NREGS=16): ADD x17,x1,x2 → illegal_o=1, we=0, no pending bit set. Opcode 0x7F → illegal_o=1.
